// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit barrel shifter between two ports.
// The result is held in a single registered stage with valid/ready return.
module barrel_shifter (
  input  logic [31:0] a,
  input  logic [4:0]  amt,
  input  logic        left,
  output logic [31:0] res
);

  logic [31:0] stg [0:5];

  assign stg[0] = a;

  // log2 stages: stage i shifts by 2**i when amt[i] is set
  for (genvar i = 0; i < 5; i++) begin : g_stage
    localparam int SH = 1 << i;
    logic [31:0] shl;
    logic [31:0] shr;
    assign shl = stg[i] << SH;
    assign shr = stg[i] >> SH;
    assign stg[i+1] = amt[i] ? (left ? shl : shr) : stg[i];
  end

  assign res = stg[5];

endmodule

module shift_arbiter #(
  parameter logic PRIO_RESET = 1'b0,
  parameter int   CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [31:0]      req_a_0,
  input  logic [31:0]      req_a_1,
  input  logic [4:0]       req_amt_0,
  input  logic [4:0]       req_amt_1,
  input  logic             req_left_0,
  input  logic             req_left_1,
  output logic             rsp_valid_0,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_0,
  input  logic             rsp_ready_1,
  output logic [31:0]      rsp_res_0,
  output logic [31:0]      rsp_res_1,
  output logic [CNT_W-1:0] grant_cnt_0,
  output logic [CNT_W-1:0] grant_cnt_1
);

  logic             out_valid;
  logic             out_owner;
  logic [31:0]      out_res;
  logic             prio;
  logic [CNT_W-1:0] cnt_0;
  logic [CNT_W-1:0] cnt_1;

  logic        own_ready;
  logic        free;
  logic        gnt;
  logic        acc_0;
  logic        acc_1;
  logic        acc;
  logic [31:0] sh_a;
  logic [4:0]  sh_amt;
  logic        sh_left;
  logic [31:0] sh_res;

  assign own_ready = out_owner ? rsp_ready_1 : rsp_ready_0;

  // a draining result frees the stage in the same cycle
  assign free = !out_valid || own_ready;

  always_comb begin
    gnt = prio;
    unique case (1'b1)
      req_valid_0 && !req_valid_1: gnt = 1'b0;
      req_valid_1 && !req_valid_0: gnt = 1'b1;
      default:                     gnt = prio;
    endcase
  end

  assign req_ready_0 = free && !gnt && !rst;
  assign req_ready_1 = free && gnt && !rst;

  assign acc_0 = req_valid_0 && req_ready_0;
  assign acc_1 = req_valid_1 && req_ready_1;
  assign acc   = acc_0 || acc_1;

  assign sh_a    = gnt ? req_a_1    : req_a_0;
  assign sh_amt  = gnt ? req_amt_1  : req_amt_0;
  assign sh_left = gnt ? req_left_1 : req_left_0;

  barrel_shifter u_shifter (
    .a    (sh_a),
    .amt  (sh_amt),
    .left (sh_left),
    .res  (sh_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_owner <= 1'b0;
      out_res   <= '0;
      prio      <= PRIO_RESET;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_owner <= acc_1;
      out_res   <= sh_res;
      prio      <= !acc_1;
    end else if (out_valid && own_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_0 <= '0;
      cnt_1 <= '0;
    end else begin
      if (acc_0 && cnt_0 != '1) cnt_0 <= cnt_0 + 1'b1;
      if (acc_1 && cnt_1 != '1) cnt_1 <= cnt_1 + 1'b1;
    end
  end

  assign rsp_valid_0 = out_valid && !out_owner;
  assign rsp_valid_1 = out_valid && out_owner;
  assign rsp_res_0   = out_res;
  assign rsp_res_1   = out_res;
  assign grant_cnt_0 = cnt_0;
  assign grant_cnt_1 = cnt_1;

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one combinational 32-bit `barrel_shifter` instance between two requesters. In the FPU these are port 0, mantissa alignment (right shifts), and port 1, post-add normalization (left shifts). The block arbitrates round-robin, issues the winning operand to the shifter, and captures the result in a single registered output stage. The result returns on the winner's response channel with valid/ready backpressure. Per-port saturating grant counters are provided for performance monitoring.

## Interface
Parameters:
- PRIO_RESET, 0: requester holding priority after reset (0 or 1).
- CNT_W, 16: width of the grant counters.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_0 / req_valid_1  in  1  request present.
- req_ready_0 / req_ready_1  out  1  request accepted this cycle when high together with valid.
- req_a_0 / req_a_1  in  32  operand to shift.
- req_amt_0 / req_amt_1  in  5  shift amount, 0..31.
- req_left_0 / req_left_1  in  1  1 = logical left shift, 0 = logical right shift; zero fill in both cases.
- rsp_valid_0 / rsp_valid_1  out  1  result available for that port.
- rsp_ready_0 / rsp_ready_1  in  1  consumer takes the result.
- rsp_res_0 / rsp_res_1  out  32  shifted result; both ports driven from the shared result register.
- grant_cnt_0 / grant_cnt_1  out  CNT_W  accepted-request count, saturating at all-ones.

## Operation
- State:
  - out_valid: result register holds an undelivered result.
  - out_owner: 1 bit, the port that owns the held result.
  - out_res: 32-bit result register.
  - prio: round-robin pointer.
  - grant_cnt_0 and grant_cnt_1.
- Stage-free condition: free = !out_valid || (rsp_valid_owner && rsp_ready_owner). A result draining this cycle frees the stage in the same cycle, which allows full throughput.
- Arbitration (combinational):
  - Only requester k valid: grant k.
  - Both valid: grant prio.
  - Grant applies only when free; otherwise both req_ready are 0.
  - req_ready_k = free && grant==k && !rst. Ready never depends on the other port's ready.
- Shifter mux: the granted port's a/amt/left drive the single barrel_shifter instance.
- On accept (req_valid_k && req_ready_k):
  - out_res ← shifter output.
  - out_owner ← k.
  - out_valid ← 1.
  - prio ← 1-k.
  - grant_cnt_k increments unless it is all-ones.
- Drain with no new accept in the same cycle: out_valid ← 0. out_res retains its value.
- Outputs:
  - rsp_valid_k = out_valid && out_owner==k.
  - rsp_res_k = out_res for both ports; consumers qualify it with rsp_valid.
- Request payload may change while valid is low. Once a requester raises valid it holds valid and payload stable until accepted.
- Shift semantics:
  - Right shift: res = a >> amt.
  - Left shift: res = a << amt.
  - amt = 0 returns a unchanged.
- Reset (synchronous, rst high at a rising edge):
  - out_valid=0, out_owner=0, out_res=0, prio=PRIO_RESET, both grant counters 0.
  - All req_ready are 0 while rst is high.
  - A result pending when reset is applied is discarded and never presented.

## Timing
- Latency: request accepted at edge N; rsp_valid is high and rsp_res is valid after edge N, i.e. in cycle N+1.
- Throughput: one accept per cycle while the consumer keeps rsp_ready high.
- Backpressure: while rsp_valid_k=1 and rsp_ready_k=0, out_res, out_owner and rsp_valid hold, and no request from either port is accepted.
- Simultaneous drain and accept at the same edge: the new result replaces the old one. rsp_valid stays high without a bubble; the owner may change.
- Fairness: with both ports continuously valid and the stage free every cycle, grants alternate 0,1,0,1… starting from PRIO_RESET. Neither port waits more than one grant of the other.
- Counters update on the same edge as the accept; the new value is visible in the next cycle.
- First accept after reset deasserts: the earliest accept is the first edge with rst low.

## Test plan
- Single right shift: port 0 sends a=0x8000_0000, amt=4, left=0 → rsp_valid_0 one cycle after accept with rsp_res=0x0800_0000; rsp_valid_1 stays 0; grant_cnt_0=1.
- Single left shift and edge amounts: port 1 sends a=0x0000_0001, amt=31, left=1 → 0x8000_0000. Port 1 sends a=0xDEAD_BEEF, amt=0 → 0xDEAD_BEEF.
- Contention: both ports valid every cycle, rsp_ready both 1, PRIO_RESET=0 → accepts alternate 0,1,0,1 for 8 cycles with results in back-to-back cycles; each grant counter equals 4.
- Backpressure: port 0 result pending, rsp_ready_0=0 for 5 cycles with port 1 valid → req_ready_1=0 throughout and out_res stable. When rsp_ready_0 rises, port 1 is accepted on that same edge and rsp_valid_1 follows in the next cycle.
- Reset mid-operation: assert rst while rsp_valid_0=1 and both requests valid → next cycle all rsp_valid 0, counters 0, req_ready 0 while rst is high. After release, the first contended grant goes to PRIO_RESET.
- Counter saturation (CNT_W=4): issue 20 requests from port 0 → grant_cnt_0 reaches 15 and holds, with no wrap to 0.
